// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Purpose  : Shared types and constants for the seven-segment display scanner:
//            scan state encoding, all-off segment/anode patterns and the
//            active-low hex segment table (bit order {g,f,e,d,c,b,a}).
// Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Entry n holds the active-low segment pattern for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage : display_pkg
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_seg
// Purpose  : Combinational 4-bit hex digit to active-low 7-segment decode.
// Revision : 1.0 - initial release
// ============================================================================
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_SEG[nibble];

endmodule : hex_to_seg
`default_nettype wire

// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : display_scanner
// Purpose  : Time-multiplexed driver for a 4-digit common-anode 7-segment
//            display. Digits are lit one at a time with an all-off blanking
//            gap between them; the displayed word is latched only while
//            blanking ahead of digit 0, so a frame never mixes two values.
//            Optional macro DISPLAY_LEADING_ZERO_BLANK_EN suppresses the
//            anodes of leading-zero digits (digit 0 is always lit).
// Revision : 1.0 - initial release
// ============================================================================
module display_scanner
  import display_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n
);

  // One counter serves both states, so size it for the longer one.
  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        idx;
  logic [15:0]       shadow;
  logic [3:0]        nibble;
  logic [6:0]        dec_seg;
  logic [6:0]        seg_next;
  logic [3:0]        an_next;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= BLANK;
    else       state <= state_next;
  end

  // Next-state logic: each state lasts until the shared counter hits its limit.
  always_comb begin
    state_next = state;
    case (state)
      BLANK:   if (cnt == BLANK_LAST) state_next = DRIVE;
      DRIVE:   if (cnt == DRIVE_LAST) state_next = BLANK;
      default: state_next = BLANK;
    endcase
  end

  // Slot counter, digit index and frame shadow of the displayed word.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      idx    <= 2'd0;
      shadow <= 16'h0000;
    end else begin
      cnt <= (state_next != state) ? '0 : cnt + 1'b1;
      if (state == DRIVE && state_next == BLANK) idx <= idx + 2'd1;
      // Keep sampling through the whole pre-digit-0 gap; the last sample wins.
      if (state == BLANK && idx == 2'd0) shadow <= value;
    end
  end

  assign nibble = shadow[{idx, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg_n  (dec_seg)
  );

  // Output decode for the current state; registered below, hence one cycle late.
  always_comb begin
    seg_next = SEG_OFF;
    an_next  = AN_OFF;
    if (state == DRIVE) begin
      seg_next = dec_seg;
      an_next  = ~(4'b0001 << idx);
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
      // A digit is a leading zero when it and every digit above it are zero.
      if (idx != 2'd0 && (shadow >> {idx, 2'b00}) == 16'h0000) an_next = AN_OFF;
`endif
    end
  end

  // Registered outputs so the pads never see decode glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_n <= SEG_OFF;
      an_n  <= AN_OFF;
    end else begin
      seg_n <= seg_next;
      an_n  <= an_next;
    end
  end

endmodule : display_scanner
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scanner
// Purpose  : Self-checking bench for display_scanner (CLK_DIV=4,
//            BLANK_CYCLES=2). Stimulus pushes the expected outputs of every
//            clock edge into a queue; a monitor pops and compares one entry
//            on each falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scanner;

  localparam int CLK_DIV      = 4;
  localparam int BLANK_CYCLES = 2;
  localparam int SLOT         = CLK_DIV + BLANK_CYCLES;
  localparam int FRAME        = 4 * SLOT;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
    int         tag;
  } exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'hFFFF;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_no  = 0;

  // Hand-entered active-low segment patterns for hex 0..F.
  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  display_scanner #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .seg_n (seg_n),
    .an_n  (an_n)
  );

  always #5 clk = ~clk;

  // Wait for the next edge, then queue what the outputs must show after it.
  task automatic cyc(input logic [6:0] s, input logic [3:0] a);
    exp_t e;
    @(posedge clk);
    #1;
    edge_no++;
    e.seg = s;
    e.an  = a;
    e.tag = edge_no;
    exp_q.push_back(e);
  endtask

  function automatic logic [3:0] lit_an(input int d, input logic [15:0] shv);
    logic [3:0] a;
    a = 4'hF;
    a[d] = 1'b0;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    if (d > 0 && (shv >> (4 * d)) == 16'h0000) a = 4'hF;
`endif
    return a;
  endfunction

  function automatic logic [6:0] lit_seg(input int d, input logic [15:0] shv);
    logic [3:0] nib;
    nib = shv[4*d +: 4];
    return seg_tbl[nib];
  endfunction

  // Expect ncyc edges of a frame showing shv; optionally switch value after edge sw_at.
  task automatic frame(input logic [15:0] shv, input int ncyc,
                       input int sw_at, input logic [15:0] sw_val);
    for (int i = 0; i < ncyc; i++) begin
      int d, pos;
      d   = i / SLOT;
      pos = i % SLOT;
      if (pos < BLANK_CYCLES) cyc(7'h7F, 4'hF);
      else                    cyc(lit_seg(d, shv), lit_an(d, shv));
      if (i == sw_at) value = sw_val;
    end
  endtask

  // Monitor: one comparison per falling edge while expectations are pending.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (seg_n !== e.seg || an_n !== e.an) begin
        failures++;
        $display("FAIL edge%0d outputs: seg_n=%h an_n=%b, expected seg_n=%h an_n=%b",
                 e.tag, seg_n, an_n, e.seg, e.an);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held for 3 edges with an all-F value: outputs must stay off.
    reset = 1'b1;
    value = 16'hFFFF;
    repeat (3) cyc(7'h7F, 4'hF);
    reset = 1'b0;
    value = 16'h1234;

    // Two complete frames of 1234 (first two edges after release are off).
    frame(16'h1234, FRAME, -1, 16'h0000);
    frame(16'h1234, FRAME, -1, 16'h0000);

    // Switch to ABCD while digit 1 is lit: this frame still shows 1234.
    frame(16'h1234, FRAME, BLANK_CYCLES + SLOT, 16'hABCD);
    frame(16'hABCD, FRAME, FRAME - 1, 16'h0005);

    // Leading zeros (blanked only when the macro is defined).
    frame(16'h0005, FRAME, FRAME - 1, 16'h0000);
    frame(16'h0000, FRAME, FRAME - 1, 16'h1234);

    // Reset sampled on the edge ending the 2nd DRIVE cycle of digit 2.
    frame(16'h1234, 2 * SLOT + BLANK_CYCLES + 1, -1, 16'h0000);
    reset = 1'b1;
    cyc(7'h7F, 4'hF);
    reset = 1'b0;
    frame(16'h1234, FRAME, -1, 16'h0000);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_display_scanner
`default_nettype wire

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It consumes the 16-bit `display_out` word produced by the CPU's memory-mapped display register and shows it as four hex digits. Digits are scanned one at a time, with a blanking interval between digits to suppress ghosting. A new value is latched only at frame start, so a frame never shows a mix of two values.

## Interface
- `CLK_DIV`, default 50000: cycles each digit is driven per frame; must be ≥ 2.
- `BLANK_CYCLES`, default 16: cycles all anodes are off between digits; must be ≥ 1.
- `clk`  in  1  system clock; one clock domain. This block does not use `clk_enable`.
- `reset`  in  1  synchronous, active-high reset.
- `value`  in  16  word to display; connect to the CPU's `display_out`.
- `seg_n`  out  7  segment cathodes, active-low; bit order `{g,f,e,d,c,b,a}`.
- `an_n`  out  4  digit anodes, active-low; `an_n[i]` shows `value[4i+3:4i]`.

## Operation
- FSM states:
  - `BLANK`: all digits off, runs for `BLANK_CYCLES` cycles.
  - `DRIVE`: one digit lit, runs for `CLK_DIV` cycles.
- Counters:
  - `cnt`: one shared counter; counts 0..limit−1 in the current state, then clears on every state transition.
  - `idx`: 2-bit digit index.
- Transitions:
  - `BLANK` → `DRIVE` when `cnt == BLANK_CYCLES−1`.
  - `DRIVE` → `BLANK` when `cnt == CLK_DIV−1`; `idx` increments at the same time, wrapping 3 → 0.
- Shadow register `shadow[15:0]`:
  - Loads `value` on every cycle where state is `BLANK` and `idx == 0`.
  - Holds at all other times.
  - The last `value` sampled before `DRIVE` of digit 0 is displayed for the whole frame.
- Output rules:
  - In `BLANK`: `seg_n = 7'h7F`, `an_n = 4'hF`.
  - In `DRIVE`: `an_n` has only bit `idx` low; `seg_n = hex_decode(shadow[4*idx +: 4])`.
- Hex decode table (`seg_n`):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

## Timing
- `seg_n` and `an_n` are registered and lag the FSM by exactly 1 cycle.
- Reset state: `BLANK`, `idx = 0`, `cnt = 0`, `shadow = 16'h0000`.
- Reset values of outputs: `seg_n = 7'h7F`, `an_n = 4'hF`, on the edge where `reset` is sampled high.
- After `reset` falls, the first lit digit (digit 0) appears `BLANK_CYCLES+1` cycles later.
- Frame period: `4·(CLK_DIV+BLANK_CYCLES)` cycles; each digit is lit for exactly `CLK_DIV` consecutive cycles.
- Mid-frame `value` changes:
  - Ignored until the next frame's `BLANK` with `idx == 0`.
  - Latency from a `value` change to visibility is at most one frame period + 1 cycle.
- Reset asserted mid-`DRIVE`: outputs go fully off on the next edge, and the scan restarts at digit 0.
- Parameters outside their stated minimums are unsupported; the bench does not cover them.

## Configuration
- `DISPLAY_LEADING_ZERO_BLANK_EN` defined: during `DRIVE` of digit `idx > 0`, `an_n` stays `4'hF` if `shadow[15:4*idx]` is all zero. Digit 0 is always lit. Slot timing is unchanged.
- Not defined: all four digits are always lit, leading zeros included.

## Structure
- Package `display_pkg`:
  - state enum (`BLANK`, `DRIVE`)
  - `SEG_OFF = 7'h7F`
  - `AN_OFF = 4'hF`
  - 16-entry hex segment constant table
- Sub-module `hex_to_seg`: combinational 4-bit → 7-bit decode using the package table. This block holds one instance, fed by the shadow-nibble mux.
- All sequential logic stays in `display_scanner`: FSM, `cnt`, `idx`, `shadow`, output registers.

## Test plan
All scenarios use `CLK_DIV=4`, `BLANK_CYCLES=2`.
- **Reset:** hold `reset` 3 cycles with `value=16'hFFFF` → `seg_n=7'h7F` and `an_n=4'hF` throughout, and for 2 cycles after release.
- **Scan order:** `value=16'h1234` → repeating sequence:
  - 2 cycles off
  - `an_n=1110`/`seg_n=19` for 4 cycles, then 2 cycles off
  - `1101`/`30` for 4 cycles, then 2 cycles off
  - `1011`/`24` for 4 cycles, then 2 cycles off
  - `0111`/`79` for 4 cycles
  - period 24 cycles
- **Tear-free update:** switch to `16'hABCD` while digit 1 is lit → digits 2 and 3 still show `24` and `79`; the next frame shows `21`, `46`, `03`, `08`.
- **Leading-zero blanking:** `value=16'h0005`.
  - With the macro: only `an_n=1110`/`seg_n=12` is ever lit; the other slots stay `an_n=F`.
  - Without the macro: digits 1–3 show `seg_n=40`.
- **All-zero value:** `value=16'h0000` with the macro → digit 0 is lit with `seg_n=40`.
- **Reset mid-operation:** assert `reset` on the 2nd cycle of digit 2 `DRIVE` → outputs go off on the next edge; after release, digit 0 is lit 3 cycles later.
